// File: rtl/i2c_slave_regs_if.sv
// i2c_slave_regs_if: I2C pin bundle plus the register-write
// report and bus status of the I2C register target.
interface i2c_slave_regs_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       sda_t;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       bus_active;

    modport slave (
        input  scl_i, sda_i,
        output sda_o, sda_t,
        output reg_wr_en, reg_wr_addr, reg_wr_data,
        output busy, bus_active
    );

    modport master (
        output scl_i, sda_i,
        input  sda_o, sda_t,
        input  reg_wr_en, reg_wr_addr, reg_wr_data,
        input  busy, bus_active
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target with a 16x8 register file,
// pointer-set writes and auto-incrementing reads.
module i2c_slave_regs #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 4
) (
    input logic             clk,
    input logic             rst,
    i2c_slave_regs_if.slave bus
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WR, WR_ACK, RD, RD_ACK, IGNORE
    } state_t;

    // bit 1 carries SCL, bit 0 carries SDA
    logic [1:0]    sy1, sy2, flt, flt_p;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sy1     <= 2'b11;
            sy2     <= 2'b11;
            flt     <= 2'b11;
            flt_p   <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sy1   <= {bus.scl_i, bus.sda_i};
            sy2   <= sy1;
            flt_p <= flt;
            for (int i = 0; i < 2; i++) begin
                if (sy2[i] == flt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                    flt[i]  <= sy2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl, sda, rise, fall, start, stop;

    assign scl   = flt[1];
    assign sda   = flt[0];
    assign rise  = scl & ~flt_p[1];
    assign fall  = ~scl & flt_p[1];
    assign start = scl & flt_p[1] & flt_p[0] & ~sda;
    assign stop  = scl & flt_p[1] & ~flt_p[0] & sda;

    state_t     st, st_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic [3:0] ptr, ptr_n;
    logic       rw, rw_n;
    logic       ack_ph, ack_n;
    logic       sdt, sdt_n;
    logic       busy_q, busy_n;
    logic       act_q, act_n;
    logic       wen, wen_n;
    logic [3:0] waddr, waddr_n;
    logic [7:0] wdata, wdata_n;
    logic [7:0] byte_in;
    logic [7:0] regs [16];

    assign byte_in = {sh[6:0], sda};

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        rw_n    = rw;
        ack_n   = ack_ph;
        sdt_n   = sdt;
        busy_n  = busy_q;
        act_n   = act_q;
        wen_n   = 1'b0;
        waddr_n = waddr;
        wdata_n = wdata;
        if (stop) begin
            st_n   = IDLE;
            sdt_n  = 1'b1;
            busy_n = 1'b0;
            act_n  = 1'b0;
        end else if (start) begin
            st_n  = ADDR;
            cnt_n = '0;
            ack_n = 1'b0;
            sdt_n = 1'b1;
            act_n = 1'b1;
        end else begin
            unique case (st)
                IDLE: ;
                ADDR: if (rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = '0;
                        if (byte_in[7:1] == DEVICE_ADDR) begin
                            st_n   = ADDR_ACK;
                            rw_n   = byte_in[0];
                            busy_n = 1'b1;
                        end else begin
                            st_n   = IGNORE;
                            sdt_n  = 1'b1;
                            busy_n = 1'b0;
                        end
                    end
                end
                // ACK is held from the 8th to the 9th falling edge
                ADDR_ACK, PTR_ACK, WR_ACK: if (fall) begin
                    if (!ack_ph) begin
                        sdt_n = 1'b0;
                        ack_n = 1'b1;
                    end else begin
                        ack_n = 1'b0;
                        cnt_n = '0;
                        sdt_n = 1'b1;
                        if (st == ADDR_ACK && rw) begin
                            st_n  = RD;
                            sh_n  = regs[ptr];
                            sdt_n = regs[ptr][7];
                        end else if (st == ADDR_ACK) begin
                            st_n = PTR;
                        end else begin
                            st_n = WR;
                        end
                    end
                end
                PTR: if (rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = '0;
                        ptr_n = byte_in[3:0];
                        st_n  = PTR_ACK;
                    end
                end
                WR: if (rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n   = '0;
                        wen_n   = 1'b1;
                        waddr_n = ptr;
                        wdata_n = byte_in;
                        ptr_n   = ptr + 4'd1;
                        st_n    = WR_ACK;
                    end
                end
                // cnt==8 marks a reloaded byte whose MSB is not yet out
                RD: if (fall) begin
                    if (cnt == 4'd8) begin
                        sdt_n = sh[7];
                        cnt_n = '0;
                    end else if (cnt == 4'd7) begin
                        sdt_n = 1'b1;
                        ptr_n = ptr + 4'd1;
                        st_n  = RD_ACK;
                    end else begin
                        sh_n  = {sh[6:0], 1'b0};
                        sdt_n = sh[6];
                        cnt_n = cnt + 4'd1;
                    end
                end
                RD_ACK: if (rise) begin
                    if (!sda) begin
                        sh_n  = regs[ptr];
                        cnt_n = 4'd8;
                        st_n  = RD;
                    end else begin
                        sdt_n = 1'b1;
                        st_n  = IGNORE;
                    end
                end
                IGNORE: sdt_n = 1'b1;
                default: st_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            ptr    <= '0;
            rw     <= 1'b0;
            ack_ph <= 1'b0;
            sdt    <= 1'b1;
            busy_q <= 1'b0;
            act_q  <= 1'b0;
            wen    <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            ptr    <= ptr_n;
            rw     <= rw_n;
            ack_ph <= ack_n;
            sdt    <= sdt_n;
            busy_q <= busy_n;
            act_q  <= act_n;
            wen    <= wen_n;
            waddr  <= waddr_n;
            wdata  <= wdata_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wen_n) begin
            regs[ptr] <= byte_in;
        end
    end

    assign bus.sda_o       = 1'b0;
    assign bus.sda_t       = sdt;
    assign bus.reg_wr_en   = wen;
    assign bus.reg_wr_addr = waddr;
    assign bus.reg_wr_data = wdata;
    assign bus.busy        = busy_q;
    assign bus.bus_active  = act_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master driving the register
// target, checked against a transaction-level register model.
module tb_i2c_slave_regs;

    localparam logic [6:0] DEV = 7'h50;
    localparam int FL = 4;
    localparam int Q  = 20;
    localparam int H  = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    i2c_slave_regs_if bus();

    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & bus.sda_t;

    i2c_slave_regs #(.DEVICE_ADDR(DEV), .FILTER_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // transaction-level model: register contents, pointer, pending writes
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr = '0;
    bit          m_first = 1'b0;
    logic [11:0] exp_q [$];
    bit          quiet = 1'b0;
    logic [11:0] e_cur;

    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            if (bus.sda_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sda_o: got %b expected 0", bus.sda_o);
            end
            if (bus.reg_wr_en === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_evt: got %0h:%02h expected none",
                             bus.reg_wr_addr, bus.reg_wr_data);
                end else begin
                    e_cur = exp_q.pop_front();
                    if ({bus.reg_wr_addr, bus.reg_wr_data} !== e_cur) begin
                        n_fail++;
                        $display("FAIL wr_evt: got %0h:%02h expected %0h:%02h",
                                 bus.reg_wr_addr, bus.reg_wr_data,
                                 e_cur[11:8], e_cur[7:0]);
                    end
                end
            end
            if (quiet) begin
                n_tests++;
                if (bus.sda_t !== 1'b1 || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL quiet: got sda_t=%b busy=%b expected 1/0",
                             bus.sda_t, bus.busy);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic v);
        m_sda = v;    tick(Q);
        m_scl = 1'b1; tick(H);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic v);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(H / 2);
        v = m_sda & bus.sda_t;
        tick(H / 2);
        m_scl = 1'b0; tick(Q);
    endtask

    // g selects a bit whose SCL high phase carries a short low glitch
    task automatic send(input logic [7:0] b, input int g, output logic ack);
        logic ln;
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1;
            if (i == g) begin
                tick(10);
                m_scl = 1'b0; tick(FL - 1);
                m_scl = 1'b1; tick(H - 10 - (FL - 1));
            end else begin
                tick(H);
            end
            m_scl = 1'b0; tick(Q);
        end
        get_bit(ln);
        ack = ~ln;
    endtask

    task automatic recv(output logic [7:0] b, input logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            get_bit(v);
            b[i] = v;
        end
        put_bit(~ack);
    endtask

    task automatic m_addr(input logic [7:0] b);
        logic a;
        send(b, -1, a);
        chk("addr_ack", {31'd0, a}, {31'd0, b[7:1] == DEV});
        m_first = 1'b1;
    endtask

    task automatic m_wr(input logic [7:0] b, input int g);
        logic a;
        if (m_first) begin
            m_ptr = b[3:0];
        end else begin
            exp_q.push_back({m_ptr, b});
            m_regs[m_ptr] = b;
            m_ptr = m_ptr + 4'd1;
        end
        m_first = 1'b0;
        send(b, g, a);
        chk("data_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic m_rd(input logic ack, input logic [7:0] lit);
        logic [7:0] b;
        recv(b, ack);
        chk("rd_model", {24'd0, b}, {24'd0, m_regs[m_ptr]});
        chk("rd_literal", {24'd0, b}, {24'd0, lit});
        m_ptr = m_ptr + 4'd1;
    endtask

    initial begin
        logic a;
        bit   got;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        tick(4);
        chk("rst_sda_t", {31'd0, bus.sda_t}, 32'd1);
        chk("rst_sda_o", {31'd0, bus.sda_o}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.reg_wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, bus.reg_wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.reg_wr_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_bus_active", {31'd0, bus.bus_active}, 32'd0);
        rst = 1'b0;
        tick(20);

        // basic write of two bytes from pointer 3
        do_start();
        m_addr(8'hA0);
        chk("busy_on", {31'd0, bus.busy}, 32'd1);
        chk("active_on", {31'd0, bus.bus_active}, 32'd1);
        m_wr(8'h03, -1);
        m_wr(8'h11, -1);
        m_wr(8'h22, -1);
        do_stop();
        chk("busy_off", {31'd0, bus.busy}, 32'd0);
        chk("active_off", {31'd0, bus.bus_active}, 32'd0);
        chk("wr_pending", exp_q.size(), 32'd0);

        do_start(); m_addr(8'hA0); m_wr(8'h03, -1);
        do_start(); m_addr(8'hA1);
        m_rd(1'b1, 8'h11);
        m_rd(1'b0, 8'h22);
        do_stop();

        // wrapping write; upper pointer nibble is ignored
        do_start(); m_addr(8'hA0);
        m_wr(8'hFF, -1); m_wr(8'hA5, -1); m_wr(8'h3C, -1); m_wr(8'h5A, -1);
        do_stop();
        chk("wr_pending", exp_q.size(), 32'd0);

        do_start(); m_addr(8'hA0); m_wr(8'h0F, -1);
        do_start(); m_addr(8'hA1);
        m_rd(1'b1, 8'hA5);
        m_rd(1'b0, 8'h3C);
        do_stop();
        do_start(); m_addr(8'hA1);
        m_rd(1'b0, 8'h5A);
        do_stop();

        // foreign address
        quiet = 1'b1;
        do_start();
        chk("foreign_active", {31'd0, bus.bus_active}, 32'd1);
        m_addr(8'hB0);
        send(8'h55, -1, a);
        chk("foreign_ack", {31'd0, a}, 32'd0);
        do_stop();
        chk("foreign_active_off", {31'd0, bus.bus_active}, 32'd0);
        quiet = 1'b0;

        // SCL glitch inside a data byte
        do_start(); m_addr(8'hA0);
        m_wr(8'h06, 2);
        m_wr(8'h96, 4);
        do_stop();
        do_start(); m_addr(8'hA0); m_wr(8'h06, -1);
        do_start(); m_addr(8'hA1);
        m_rd(1'b0, 8'h96);
        do_stop();

        // STOP after four data bits
        do_start(); m_addr(8'hA0); m_wr(8'h05, -1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        do_stop();
        chk("abort_sda_t", {31'd0, bus.sda_t}, 32'd1);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_active", {31'd0, bus.bus_active}, 32'd0);
        do_start(); m_addr(8'hA0); m_wr(8'h05, -1); m_wr(8'h77, -1);
        do_stop();
        do_start(); m_addr(8'hA0); m_wr(8'h05, -1);
        do_start(); m_addr(8'hA1);
        m_rd(1'b0, 8'h77);
        do_stop();
        chk("wr_pending", exp_q.size(), 32'd0);

        // reset while the target pulls SDA low in a read
        do_start(); m_addr(8'hA0); m_wr(8'h03, -1);
        do_start(); m_addr(8'hA1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.sda_t === 1'b0) got = 1'b1;
        end
        chk("rd_drive_low", {31'd0, got}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("midrst_sda_t", {31'd0, bus.sda_t}, 32'd1);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = '0;
        tick(5);
        rst = 1'b0;
        tick(20);
        do_start(); m_addr(8'hA0); m_wr(8'h03, -1);
        do_start(); m_addr(8'hA1);
        m_rd(1'b1, 8'h00);
        m_rd(1'b0, 8'h00);
        do_stop();

        tick(20);
        chk("wr_pending_end", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
